dca_matrix_tile_sequencer: RTL and testbench

Command-level scheduler for the DCA blocked-GEMM datapath. Accepts one GEMM command giving a tile count per dimension (M, N, K) and issues the blocked step instructions in m→n→k order to the step FIFO that feeds the matrix executor. Each step carries the tile indices and the accumulator-init, store and last flags. Steps in flight are limited by a credit counter, and a single done pulse is raised once every issued step has retired.

---
 rtl/dca_matrix_tile_sequencer.sv | 159 +++++++++++++++
 tb/tb_dca_matrix_tile_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dca_matrix_tile_sequencer.sv
// Blocked-GEMM step sequencer: walks a command's M x N x K tile space in m->n->k order,
// meters issue with an outstanding-step credit counter and pulses cmd_done once all steps retire.
module dca_matrix_tile_sequencer #(
  parameter int BW_DIM          = 8,
  parameter int MAX_OUTSTANDING = 4,
  localparam int BW_STEP        = 3*BW_DIM+3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               enable,
  output logic               busy,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [BW_DIM-1:0]  cmd_m_tiles,
  input  logic [BW_DIM-1:0]  cmd_n_tiles,
  input  logic [BW_DIM-1:0]  cmd_k_tiles,
  output logic               step_valid,
  input  logic               step_ready,
  output logic [BW_STEP-1:0] step_inst,
  input  logic               step_done,
  output logic               cmd_done,
  output logic               err_underflow
);

  localparam int BW_OUT = $clog2(MAX_OUTSTANDING+1);
  localparam logic [BW_OUT-1:0] MAX_CNT = BW_OUT'(MAX_OUTSTANDING);
  localparam logic [BW_OUT-1:0] OUT_ONE = BW_OUT'(1);
  localparam logic [BW_DIM-1:0] DIM_ONE = BW_DIM'(1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t            state_reg, state_next;
  logic [BW_DIM-1:0] m_tiles_reg, m_tiles_next;
  logic [BW_DIM-1:0] n_tiles_reg, n_tiles_next;
  logic [BW_DIM-1:0] k_tiles_reg, k_tiles_next;
  logic [BW_DIM-1:0] m_idx_reg, m_idx_next;
  logic [BW_DIM-1:0] n_idx_reg, n_idx_next;
  logic [BW_DIM-1:0] k_idx_reg, k_idx_next;
  logic [BW_OUT-1:0] outstanding_reg, outstanding_next;
  logic              err_reg, err_next;
  logic              fire;
  logic              m_wrap, n_wrap, k_wrap;

  assign m_wrap = (m_idx_reg == m_tiles_reg - DIM_ONE);
  assign n_wrap = (n_idx_reg == n_tiles_reg - DIM_ONE);
  assign k_wrap = (k_idx_reg == k_tiles_reg - DIM_ONE);

  assign busy          = (state_reg != IDLE);
  assign err_underflow = err_reg;
  // Flags are only meaningful while issuing; the word reads as zero otherwise.
  assign step_inst = (state_reg == ISSUE) ?
                     {m_idx_reg, n_idx_reg, k_idx_reg, (m_wrap & n_wrap & k_wrap), k_wrap,
                      (k_idx_reg == '0)} : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      m_tiles_reg     <= '0;
      n_tiles_reg     <= '0;
      k_tiles_reg     <= '0;
      m_idx_reg       <= '0;
      n_idx_reg       <= '0;
      k_idx_reg       <= '0;
      outstanding_reg <= '0;
      err_reg         <= 1'b0;
    end else begin
      state_reg       <= state_next;
      m_tiles_reg     <= m_tiles_next;
      n_tiles_reg     <= n_tiles_next;
      k_tiles_reg     <= k_tiles_next;
      m_idx_reg       <= m_idx_next;
      n_idx_reg       <= n_idx_next;
      k_idx_reg       <= k_idx_next;
      outstanding_reg <= outstanding_next;
      err_reg         <= err_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    m_tiles_next     = m_tiles_reg;
    n_tiles_next     = n_tiles_reg;
    k_tiles_next     = k_tiles_reg;
    m_idx_next       = m_idx_reg;
    n_idx_next       = n_idx_reg;
    k_idx_next       = k_idx_reg;
    outstanding_next = outstanding_reg;
    err_next         = err_reg;
    cmd_ready        = 1'b0;
    step_valid       = 1'b0;
    cmd_done         = 1'b0;
    fire             = 1'b0;

    case (state_reg)
      IDLE: begin
        cmd_ready = enable & ~clear;
        if (cmd_valid & enable & ~clear) begin
          m_tiles_next = cmd_m_tiles;
          n_tiles_next = cmd_n_tiles;
          k_tiles_next = cmd_k_tiles;
          m_idx_next   = '0;
          n_idx_next   = '0;
          k_idx_next   = '0;
          if (cmd_m_tiles == '0 || cmd_n_tiles == '0 || cmd_k_tiles == '0)
            state_next = DRAIN;
          else
            state_next = ISSUE;
        end
      end
      ISSUE: begin
        step_valid = enable & (outstanding_reg < MAX_CNT);
        fire       = step_valid & step_ready;
        if (fire) begin
          if (k_wrap) begin
            k_idx_next = '0;
            if (n_wrap) begin
              n_idx_next = '0;
              m_idx_next = m_idx_reg + DIM_ONE;
            end else begin
              n_idx_next = n_idx_reg + DIM_ONE;
            end
          end else begin
            k_idx_next = k_idx_reg + DIM_ONE;
          end
          if (m_wrap & n_wrap & k_wrap)
            state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (enable & ~clear & (outstanding_reg == '0)) begin
          cmd_done   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    // Retirements are counted even while stalled; a retire with nothing in flight is an error.
    if (fire & ~step_done) begin
      outstanding_next = outstanding_reg + OUT_ONE;
    end else if (~fire & step_done) begin
      if (outstanding_reg == '0)
        err_next = 1'b1;
      else
        outstanding_next = outstanding_reg - OUT_ONE;
    end

    if (clear) begin
      state_next       = IDLE;
      m_idx_next       = '0;
      n_idx_next       = '0;
      k_idx_next       = '0;
      outstanding_next = '0;
      err_next         = 1'b0;
    end
  end

endmodule

// File: tb/tb_dca_matrix_tile_sequencer.sv
// Directed bench for dca_matrix_tile_sequencer: ordering, credits, backpressure,
// zero-size commands, abort paths and outstanding-counter corner cases.
module tb_dca_matrix_tile_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        enable = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [7:0]  cmd_m_tiles = '0;
  logic [7:0]  cmd_n_tiles = '0;
  logic [7:0]  cmd_k_tiles = '0;
  logic        step_ready = 1'b0;
  logic        step_done = 1'b0;
  logic        busy, cmd_ready, step_valid, cmd_done, err_underflow;
  logic [26:0] step_inst;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  dca_matrix_tile_sequencer #(.BW_DIM(8), .MAX_OUTSTANDING(4)) dut (
    .clk(clk), .rst(rst), .clear(clear), .enable(enable), .busy(busy),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_m_tiles(cmd_m_tiles), .cmd_n_tiles(cmd_n_tiles), .cmd_k_tiles(cmd_k_tiles),
    .step_valid(step_valid), .step_ready(step_ready), .step_inst(step_inst),
    .step_done(step_done), .cmd_done(cmd_done), .err_underflow(err_underflow)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one command to completion; retire of each step is pulsed delay cycles after issue.
  task automatic run_gemm(input int m, input int n, input int k, input bit rand_ready,
                          input int delay, input string name);
    int          total_steps = m * n * k;
    int          issued = 0;
    int          outm = 0;
    int          me = 0, ne = 0, ke = 0;
    int          retire_q[$];
    bit          got_done = 1'b0;
    bit          prev_stall = 1'b0;
    logic [26:0] prev_inst = '0;
    logic [26:0] exp_inst;
    logic        exp_valid, exp_done, e_last, e_store, e_init;

    tick();
    cmd_valid   = 1'b1;
    cmd_m_tiles = 8'(m);
    cmd_n_tiles = 8'(n);
    cmd_k_tiles = 8'(k);
    step_ready  = 1'b0;
    step_done   = 1'b0;
    #1;
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s accept_ready: got=%b want=1", name, cmd_ready);
    end

    for (int cyc = 1; cyc <= 600 && !got_done; cyc++) begin
      tick();
      cmd_valid  = 1'b0;
      step_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      step_done  = 1'b0;
      if (retire_q.size() > 0 && retire_q[0] <= cyc) begin
        void'(retire_q.pop_front());
        step_done = 1'b1;
      end
      #1;
      exp_valid = (issued < total_steps) && (outm < 4);
      exp_done  = (issued == total_steps) && (outm == 0);
      total++;
      if ({step_valid, cmd_done} !== {exp_valid, exp_done}) begin
        bad++;
        $display("FAIL %s cycle%0d valid/done: got=%b%b want=%b%b", name, cyc,
                 step_valid, cmd_done, exp_valid, exp_done);
      end
      if (prev_stall) begin
        total++;
        if (step_valid !== 1'b1 || step_inst !== prev_inst) begin
          bad++;
          $display("FAIL %s cycle%0d stall_stable: got=%b/%h want=1/%h", name, cyc,
                   step_valid, step_inst, prev_inst);
        end
      end
      if (step_valid && step_ready) begin
        e_init   = (ke == 0);
        e_store  = (ke == k - 1);
        e_last   = (me == m - 1) && (ne == n - 1) && (ke == k - 1);
        exp_inst = {8'(me), 8'(ne), 8'(ke), e_last, e_store, e_init};
        total++;
        if (step_inst !== exp_inst) begin
          bad++;
          $display("FAIL %s step%0d inst: got=%h want=%h", name, issued, step_inst, exp_inst);
        end
        $display("%s step %0d idx=(%0d,%0d,%0d) inst=%h", name, issued, me, ne, ke, step_inst);
        if (ke == k - 1) begin
          ke = 0;
          if (ne == n - 1) begin
            ne = 0;
            me++;
          end else begin
            ne++;
          end
        end else begin
          ke++;
        end
        issued++;
        outm++;
        retire_q.push_back(cyc + delay);
      end
      if (step_done) outm--;
      if (cmd_done) got_done = 1'b1;
      prev_stall = step_valid & ~step_ready;
      prev_inst  = step_inst;
    end

    step_done  = 1'b0;
    step_ready = 1'b0;
    total++;
    if (!got_done || issued != total_steps) begin
      bad++;
      $display("FAIL %s completion: got done=%b steps=%0d want done=1 steps=%0d", name,
               got_done, issued, total_steps);
    end
    tick();
    total++;
    if ({busy, cmd_ready, cmd_done} !== 3'b010) begin
      bad++;
      $display("FAIL %s post_done_idle: got busy/ready/done=%b%b%b want=010", name,
               busy, cmd_ready, cmd_done);
    end
    $display("%s complete steps=%0d", name, issued);
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    enable = 1'b1;
    #12;
    total++;
    if ({busy, step_valid, cmd_done, err_underflow, cmd_ready} !== 5'b00001) begin
      bad++;
      $display("FAIL reset_outputs: got=%b want=00001",
               {busy, step_valid, cmd_done, err_underflow, cmd_ready});
    end
    total++;
    if (step_inst !== 27'd0) begin
      bad++;
      $display("FAIL reset_step_inst: got=%h want=0", step_inst);
    end
    enable = 1'b0;
    #1;
    total++;
    if (cmd_ready !== 1'b0) begin
      bad++;
      $display("FAIL enable_gates_ready: got=%b want=0", cmd_ready);
    end
    enable = 1'b1;
    tick();
    rst = 1'b0;
    $display("reset released");
  endtask

  task automatic test_order();
    run_gemm(2, 2, 2, 1'b0, 2, "order_2x2x2");
  endtask

  task automatic test_credit();
    run_gemm(1, 1, 6, 1'b0, 10, "credit_1x1x6");
  endtask

  task automatic test_backpressure();
    run_gemm(3, 2, 1, 1'b1, 2, "backpressure_3x2x1");
  endtask

  task automatic test_zero_dim();
    run_gemm(2, 2, 0, 1'b0, 2, "zero_k");
  endtask

  // Steady state at 3 in flight: handshake and retire coincide every cycle.
  task automatic test_counter_corner();
    run_gemm(1, 1, 8, 1'b0, 3, "same_cycle_1x1x8");
  endtask

  // Starts a 2x2x2 command and lets exactly three steps handshake with none retired.
  task automatic start_partial(input string name, output int hs);
    hs = 0;
    tick();
    cmd_valid   = 1'b1;
    cmd_m_tiles = 8'd2;
    cmd_n_tiles = 8'd2;
    cmd_k_tiles = 8'd2;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step_ready = 1'b1;
      #1;
      if (step_valid && step_ready) hs++;
      tick();
    end
    step_ready = 1'b0;
    $display("%s partial handshakes=%0d", name, hs);
  endtask

  task automatic test_clear();
    int hs;
    start_partial("clear", hs);
    total++;
    if (hs != 3) begin
      bad++;
      $display("FAIL clear_prefill: got=%0d handshakes want=3", hs);
    end
    clear = 1'b1;
    #1;
    total++;
    if (cmd_done !== 1'b0) begin
      bad++;
      $display("FAIL clear_no_done: got=%b want=0", cmd_done);
    end
    tick();
    clear = 1'b0;
    #1;
    total++;
    if ({busy, step_valid, cmd_done, cmd_ready} !== 4'b0001 || step_inst !== 27'd0) begin
      bad++;
      $display("FAIL clear_idle: got=%b/%h want=0001/0",
               {busy, step_valid, cmd_done, cmd_ready}, step_inst);
    end
    run_gemm(1, 1, 1, 1'b0, 2, "after_clear_1x1x1");
  endtask

  task automatic test_rst();
    int hs;
    start_partial("rst", hs);
    rst = 1'b1;
    #1;
    total++;
    if ({busy, step_valid, cmd_done, err_underflow} !== 4'b0000 || step_inst !== 27'd0) begin
      bad++;
      $display("FAIL rst_async: got=%b/%h want=0000/0",
               {busy, step_valid, cmd_done, err_underflow}, step_inst);
    end
    tick();
    rst = 1'b0;
    #1;
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_ready: got=%b want=1", cmd_ready);
    end
    run_gemm(1, 1, 1, 1'b0, 2, "after_rst_1x1x1");
  endtask

  task automatic test_underflow();
    tick();
    step_done = 1'b1;
    #1;
    total++;
    if (err_underflow !== 1'b0) begin
      bad++;
      $display("FAIL underflow_pre: got=%b want=0", err_underflow);
    end
    tick();
    step_done = 1'b0;
    #1;
    total++;
    if (err_underflow !== 1'b1) begin
      bad++;
      $display("FAIL underflow_set: got=%b want=1", err_underflow);
    end
    run_gemm(1, 1, 1, 1'b0, 2, "under_err_1x1x1");
    total++;
    if (err_underflow !== 1'b1) begin
      bad++;
      $display("FAIL underflow_sticky: got=%b want=1", err_underflow);
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    #1;
    total++;
    if (err_underflow !== 1'b0) begin
      bad++;
      $display("FAIL underflow_clear: got=%b want=0", err_underflow);
    end
    $display("underflow sequence complete");
  endtask

  initial begin
    test_reset();
    test_order();
    test_credit();
    test_backpressure();
    test_zero_dim();
    test_counter_corner();
    test_clear();
    test_rst();
    test_underflow();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
